// File: rtl/axi_master_burst_engine.sv
// AXI burst initiator: turns one cache-line refill or write-back request into a
// single INCR burst and returns the line or a completion on a valid/ready port.
module axi_master_burst_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEATS      = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    // cache-side request port
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [BEATS*DATA_WIDTH-1:0]   req_wline,
    output logic                          resp_valid,
    output logic [BEATS*DATA_WIDTH-1:0]   resp_rline,
    output logic                          resp_err,
    // read address / data
    output logic                          ARVALID,
    input  logic                          ARREADY,
    output logic [ADDR_WIDTH-1:0]         ARADDR,
    output logic [LEN_WIDTH-1:0]          ARLEN,
    output logic [2:0]                    ARSIZE,
    output logic [1:0]                    ARBURST,
    input  logic                          RVALID,
    output logic                          RREADY,
    input  logic [DATA_WIDTH-1:0]         RDATA,
    input  logic                          RLAST,
    input  logic [1:0]                    RRESP,
    // write address / data / response
    output logic                          AWVALID,
    input  logic                          AWREADY,
    output logic [ADDR_WIDTH-1:0]         AWADDR,
    output logic [LEN_WIDTH-1:0]          AWLEN,
    output logic [2:0]                    AWSIZE,
    output logic [1:0]                    AWBURST,
    output logic                          WVALID,
    input  logic                          WREADY,
    output logic [DATA_WIDTH-1:0]         WDATA,
    output logic                          WLAST,
    input  logic                          BVALID,
    output logic                          BREADY,
    input  logic                          BRESP
);

    localparam int LINE_W = BEATS * DATA_WIDTH;
    localparam int CNT_W  = $clog2(BEATS + 1);
    localparam int OFF_W  = $clog2(BEATS * DATA_WIDTH / 8);

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(BEATS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
        ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_AW   = 3'd3;
    localparam logic [2:0] S_W    = 3'd4;
    localparam logic [2:0] S_B    = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_W-1:0]     wline_q, wline_d;
    logic [LINE_W-1:0]     rline_q, rline_d;
    logic [DATA_WIDTH-1:0] wdata_mux;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d  = req_addr & ADDR_MASK;
                    wline_d = req_wline;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = req_write ? S_AW : S_AR;
                end
            end
            S_AR: begin
                if (ARREADY) state_d = S_R;
            end
            S_R: begin
                if (RVALID) begin
                    if (RRESP != 2'b00) err_d = 1'b1;
                    // Beats past the end of the line are dropped and flagged.
                    if (cnt_q < CNT_FULL) begin
                        for (int i = 0; i < BEATS; i++) begin
                            if (cnt_q == CNT_W'(i)) rline_d[i*DATA_WIDTH +: DATA_WIDTH] = RDATA;
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                    if (RLAST) begin
                        if (cnt_q != CNT_LAST) err_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_AW: begin
                if (AWREADY) state_d = S_W;
            end
            S_W: begin
                if (WREADY) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) state_d = S_B;
                end
            end
            S_B: begin
                if (BVALID) begin
                    err_d   = err_q | BRESP;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wdata_mux = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (cnt_q == CNT_W'(i)) wdata_mux = wline_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            rline_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            rline_q <= rline_d;
        end
    end

    // The write line is pure payload and is only meaningful after acceptance.
    always_ff @(posedge clk) begin
        wline_q <= wline_d;
    end

    // Every AXI output is a decode of registered state only.
    assign req_ready  = (state_q == S_IDLE) && !rst;
    assign resp_valid = (state_q == S_DONE);
    assign resp_err   = err_q;
    assign resp_rline = rline_q;

    assign ARVALID = (state_q == S_AR);
    assign ARADDR  = addr_q;
    assign ARLEN   = LEN_WIDTH'(BEATS - 1);
    assign ARSIZE  = 3'($clog2(DATA_WIDTH / 8));
    assign ARBURST = 2'b01;
    assign RREADY  = (state_q == S_R);

    assign AWVALID = (state_q == S_AW);
    assign AWADDR  = addr_q;
    assign AWLEN   = LEN_WIDTH'(BEATS - 1);
    assign AWSIZE  = 3'($clog2(DATA_WIDTH / 8));
    assign AWBURST = 2'b01;
    assign WVALID  = (state_q == S_W);
    assign WDATA   = wdata_mux;
    assign WLAST   = (state_q == S_W) && (cnt_q == CNT_LAST);
    assign BREADY  = (state_q == S_B);

endmodule

// File: tb/tb_axi_master_burst_engine.sv
// Bench for axi_master_burst_engine: behavioural AXI slave memory, line-level
// reference model feeding a scoreboard, and a monitor that checks each response.
module tb_axi_master_burst_engine;

    localparam int NB     = 8;
    localparam int DW     = 32;
    localparam int LINE_W = NB * DW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [31:0]       req_addr = '0;
    logic [LINE_W-1:0] req_wline = '0;
    logic              resp_valid, resp_err;
    logic [LINE_W-1:0] resp_rline;
    logic              ARVALID, ARREADY, RVALID, RREADY, RLAST;
    logic [31:0]       ARADDR, AWADDR, RDATA, WDATA;
    logic [7:0]        ARLEN, AWLEN;
    logic [2:0]        ARSIZE, AWSIZE;
    logic [1:0]        ARBURST, AWBURST, RRESP;
    logic              AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY, BRESP;

    always #5 clk = ~clk;

    axi_master_burst_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(DW), .BEATS(NB), .LEN_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wline(req_wline),
        .resp_valid(resp_valid), .resp_rline(resp_rline), .resp_err(resp_err),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RLAST(RLAST), .RRESP(RRESP),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
    );

    int n_chk = 0, n_fail = 0;
    int cyc = 0, accept_cyc = 0, resp_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic finish_tb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    endtask

    // slave behaviour knobs, set per transaction by the driver
    int ar_mode = 0, aw_mode = 0, r_gap = 0, w_mode = 0, b_delay = 0;
    int rlast_at = NB - 1, rresp_beat = -1;
    logic bresp_cfg = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [LINE_W-1:0] exp_wline = '0;

    // slave memory (written by DUT) and reference memory (written by the model)
    logic [31:0] smem [int];
    logic [31:0] rmem [int];

    function automatic logic [31:0] smem_rd(int a);
        if (smem.exists(a)) return smem[a];
        return 32'hBAD0_0000 ^ 32'(a);
    endfunction

    function automatic logic [31:0] rmem_rd(int a);
        if (rmem.exists(a)) return rmem[a];
        return 32'hBAD0_0000 ^ 32'(a);
    endfunction

    int rd_active, r_idx, rd_base, aw_done, wr_base, w_idx, b_pend, b_wait;
    bit w_tog, w_stall;
    logic [31:0] prev_wdata;
    logic prev_wlast;

    task automatic slave_reset();
        rd_active = 0; r_idx = 0; rd_base = 0; aw_done = 0; wr_base = 0; w_idx = 0;
        b_pend = 0; b_wait = 0; w_tog = 1'b1; w_stall = 1'b0;
        prev_wdata = '0; prev_wlast = 1'b0;
        ARREADY = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
        RVALID = 1'b0; RDATA = '0; RLAST = 1'b0; RRESP = 2'b00;
        BVALID = 1'b0; BRESP = 1'b0;
    endtask

    // AXI slave: outputs change on the falling edge, handshakes are decided from the
    // DUT outputs (stable until the next rising edge) and the newly driven ready/valid.
    initial begin
        slave_reset();
        forever begin
            @(negedge clk);
            if (rst) begin
                slave_reset();
                continue;
            end
            RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00; RDATA = $urandom;
            if (rd_active != 0 && (r_gap == 0 || $urandom_range(3) != 0)) begin
                RVALID = 1'b1;
                RDATA  = smem_rd(rd_base + r_idx);
                RLAST  = (r_idx == rlast_at);
                RRESP  = (r_idx == rresp_beat) ? 2'b10 : 2'b00;
                chk("rready_during_burst", 64'(RREADY), 64'(1));
                if (RREADY) begin
                    if (RLAST) rd_active = 0;
                    r_idx++;
                end
            end
            ARREADY = (ar_mode != 0) ? 1'($urandom_range(1)) : 1'b1;
            if (ARVALID && ARREADY) begin
                chk("araddr", 64'(ARADDR), 64'(exp_addr));
                chk("arlen", 64'(ARLEN), 64'(NB - 1));
                chk("arsize", 64'(ARSIZE), 64'(2));
                chk("arburst", 64'(ARBURST), 64'(1));
                rd_active = 1; r_idx = 0; rd_base = int'(ARADDR >> 2);
            end
            BVALID = 1'b0; BRESP = 1'b0;
            if (b_pend != 0) begin
                if (b_wait > 0) b_wait--;
                else begin
                    BVALID = 1'b1; BRESP = bresp_cfg;
                    if (BREADY) b_pend = 0;
                end
            end
            if (w_stall) begin
                chk("w_hold_valid", 64'(WVALID), 64'(1));
                chk("w_hold_data", 64'(WDATA), 64'(prev_wdata));
                chk("w_hold_last", 64'(WLAST), 64'(prev_wlast));
            end
            WREADY = (w_mode == 0) ? 1'b1 : (w_mode == 1) ? w_tog : 1'($urandom_range(1));
            if (WVALID) begin
                chk("wvalid_after_aw", 64'(aw_done), 64'(1));
                w_tog = !w_tog;
            end
            if (WVALID && WREADY) begin
                if (w_idx < NB) chk("wdata", 64'(WDATA), 64'(exp_wline[w_idx*DW +: DW]));
                chk("wlast", 64'(WLAST), 64'(w_idx == NB - 1));
                smem[wr_base + w_idx] = WDATA;
                w_idx++;
                if (WLAST) begin
                    b_pend = 1; b_wait = b_delay; aw_done = 0;
                end
            end
            w_stall = WVALID && !WREADY;
            prev_wdata = WDATA; prev_wlast = WLAST;
            AWREADY = (aw_mode != 0) ? 1'($urandom_range(1)) : 1'b1;
            if (AWVALID && AWREADY) begin
                chk("awaddr", 64'(AWADDR), 64'(exp_addr));
                chk("awlen", 64'(AWLEN), 64'(NB - 1));
                chk("awsize", 64'(AWSIZE), 64'(2));
                chk("awburst", 64'(AWBURST), 64'(1));
                aw_done = 1; wr_base = int'(AWADDR >> 2); w_idx = 0; w_tog = 1'b1;
            end
        end
    end

    typedef struct {
        logic              err;
        logic [LINE_W-1:0] line;
        int                lat;
    } exp_t;
    exp_t sbq[$];
    logic [LINE_W-1:0] model_rline = '0;

    // response monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && resp_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL resp_unexpected: got resp_valid=1, expected no response pending");
                end else begin
                    e = sbq.pop_front();
                    chk("resp_err", 64'(resp_err), 64'(e.err));
                    chk_line("resp_rline", resp_rline, e.line);
                    if (e.lat >= 0) chk("latency", 64'(cyc - accept_cyc), 64'(e.lat));
                    chk("req_ready_in_done", 64'(req_ready), 64'(0));
                end
                resp_cnt++;
            end
        end
    end

    task automatic issue(input bit w, input logic [31:0] a, input logic [LINE_W-1:0] l);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wline = l;
        for (int k = 0; k < 200; k++) begin
            if (req_ready === 1'b1) begin
                accept_cyc = cyc; ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL req_accept_timeout: got req_ready=0 for 200 cycles, expected 1");
            finish_tb();
        end
        @(negedge clk);
        req_valid = 1'b0; req_addr = ~a; req_wline = ~l;
    endtask

    task automatic wait_resp(input int target);
        for (int k = 0; k < 3000; k++) begin
            if (resp_cnt >= target) return;
            @(negedge clk); #1;
        end
        n_chk++; n_fail++;
        $display("FAIL resp_timeout: got %0d responses, expected %0d", resp_cnt, target);
        finish_tb();
    endtask

    // Reference model: a read returns the memory line for the beats actually sent,
    // older slots keep the previous refill; errors come from RRESP, a wrong beat
    // count or BRESP.
    task automatic do_txn(input bit w, input logic [31:0] a, input logic [LINE_W-1:0] l);
        exp_t e;
        int nb, base, target;
        exp_addr  = a & 32'hFFFF_FFE0;
        exp_wline = l;
        base = int'(exp_addr >> 2);
        e.line = model_rline;
        if (w) begin
            e.err = bresp_cfg;
            e.lat = (aw_mode == 0 && w_mode == 0 && b_delay == 0) ? NB + 3 : -1;
        end else begin
            nb = rlast_at + 1;
            for (int i = 0; i < NB; i++)
                if (i < nb) e.line[i*DW +: DW] = rmem_rd(base + i);
            e.err = (rresp_beat >= 0 && rresp_beat < nb) || (nb != NB);
            e.lat = (ar_mode == 0 && r_gap == 0) ? nb + 2 : -1;
            model_rline = e.line;
        end
        sbq.push_back(e);
        target = resp_cnt + 1;
        issue(w, a, l);
        wait_resp(target);
        if (w) for (int i = 0; i < NB; i++) rmem[base + i] = l[i*DW +: DW];
        repeat ($urandom_range(2)) @(negedge clk);
    endtask

    task automatic zero_wait();
        ar_mode = 0; aw_mode = 0; r_gap = 0; w_mode = 0; b_delay = 0;
        rlast_at = NB - 1; rresp_beat = -1; bresp_cfg = 1'b0;
    endtask

    initial begin
        logic [LINE_W-1:0] l;
        logic [31:0] v, a;
        bit w;
        for (int i = 0; i < 8 * NB; i++) begin
            v = $urandom; smem[i] = v; rmem[i] = v;
        end
        for (int i = 0; i < NB; i++) begin
            smem[16 + i] = 32'h100 + 32'(i); rmem[16 + i] = 32'h100 + 32'(i);
            v = $urandom; smem[128 + i] = v; rmem[128 + i] = v;
        end
        zero_wait();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_arvalid", 64'(ARVALID), 64'(0));
        chk("rst_awvalid", 64'(AWVALID), 64'(0));
        chk("rst_wvalid", 64'(WVALID), 64'(0));
        chk("rst_rready", 64'(RREADY), 64'(0));
        chk("rst_bready", 64'(BREADY), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_araddr", 64'(ARADDR), 64'(0));
        chk_line("rst_resp_rline", resp_rline, '0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("idle_req_ready", 64'(req_ready), 64'(1));

        // zero-wait refill, then toggling-WREADY write-back
        do_txn(1'b0, 32'h44, '0);
        for (int i = 0; i < NB; i++) l[i*DW +: DW] = 32'hA0 + 32'(i);
        w_mode = 1;
        do_txn(1'b1, 32'h80, l);
        zero_wait();
        rresp_beat = 3;
        do_txn(1'b0, 32'h80, '0);
        zero_wait();
        rlast_at = 5;
        do_txn(1'b0, 32'hC4, '0);
        rlast_at = 9;
        do_txn(1'b0, 32'h20, '0);
        zero_wait();

        // reset in the middle of a write burst
        for (int i = 0; i < NB; i++) l[i*DW +: DW] = $urandom;
        exp_addr = 32'h1000; exp_wline = l;
        issue(1'b1, 32'h1000, l);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); #1;
            if (w_idx >= 5) break;
        end
        rst = 1'b1;
        slave_reset();
        @(negedge clk); #1;
        chk("abort_arvalid", 64'(ARVALID), 64'(0));
        chk("abort_awvalid", 64'(AWVALID), 64'(0));
        chk("abort_wvalid", 64'(WVALID), 64'(0));
        chk("abort_rready", 64'(RREADY), 64'(0));
        chk("abort_bready", 64'(BREADY), 64'(0));
        chk("abort_resp_valid", 64'(resp_valid), 64'(0));
        chk("abort_req_ready", 64'(req_ready), 64'(0));
        rst = 1'b0;
        model_rline = '0;
        @(negedge clk); #1;
        chk("abort_idle", 64'(req_ready), 64'(1));
        chk("abort_awaddr", 64'(AWADDR), 64'(0));
        chk_line("abort_rline", resp_rline, '0);
        repeat (5) @(negedge clk);
        do_txn(1'b0, 32'h44, '0);

        // loopback through the slave memory
        for (int i = 0; i < NB; i++) l[i*DW +: DW] = 32'(i + 1);
        do_txn(1'b1, 32'h200, l);
        do_txn(1'b0, 32'h200, '0);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            w = 1'($urandom_range(1));
            a = 32'($urandom_range(7)) * 32 + 32'($urandom_range(31));
            for (int i = 0; i < NB; i++) l[i*DW +: DW] = $urandom;
            ar_mode = int'($urandom_range(1)); aw_mode = int'($urandom_range(1));
            r_gap = int'($urandom_range(1)); w_mode = int'($urandom_range(2));
            b_delay = int'($urandom_range(2));
            bresp_cfg = ($urandom_range(5) == 0);
            rresp_beat = ($urandom_range(5) == 0) ? int'($urandom_range(NB - 1)) : -1;
            case ($urandom_range(7))
                0:       rlast_at = int'($urandom_range(NB - 2));
                1:       rlast_at = NB + int'($urandom_range(1));
                default: rlast_at = NB - 1;
            endcase
            do_txn(w, a, l);
        end
        repeat (3) @(negedge clk);
        finish_tb();
    end

endmodule
